// File: rtl/alu_flag_stage.sv
// Registered NZVC status register plus a 2-entry result skid buffer
// that evaluates each entry's branch condition on its flag snapshot.
module alu_flag_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_n,
  input  logic             in_v,
  input  logic             in_c,
  input  logic             in_z,
  input  logic             flag_we,
  input  logic [3:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_n,
  output logic             out_v,
  output logic             out_c,
  output logic             out_z,
  output logic             out_cond_true,
  output logic             stat_n,
  output logic             stat_v,
  output logic             stat_c,
  output logic             stat_z
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             n;
    logic             v;
    logic             c;
    logic             z;
    logic [3:0]       cond;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  ent_t   head;
  ent_t   tail;
  ent_t   incoming;
  logic   accept;
  logic   pop;
  logic   ct;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Snapshot follows program order: new flags, or status as it stands now.
  always_comb begin
    incoming      = '0;
    incoming.y    = in_y;
    incoming.cond = cond;
    if (flag_we) begin
      incoming.n = in_n;
      incoming.v = in_v;
      incoming.c = in_c;
      incoming.z = in_z;
    end else begin
      incoming.n = stat_n;
      incoming.v = stat_v;
      incoming.c = stat_c;
      incoming.z = stat_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_n <= 1'b0;
      stat_v <= 1'b0;
      stat_c <= 1'b0;
      stat_z <= 1'b0;
    end else if (accept && flag_we) begin
      stat_n <= in_n;
      stat_v <= in_v;
      stat_c <= in_c;
      stat_z <= in_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= '0;
      tail      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            head      <= incoming;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            tail     <= incoming;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (pop && !accept) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (accept && pop) begin
            head <= incoming;
          end
        end
        TWO: begin
          if (pop) begin
            head     <= tail;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ct = 1'b0;
    unique case (head.cond)
      4'b0000: ct = head.z;
      4'b0001: ct = ~head.z;
      4'b0010: ct = head.c;
      4'b0011: ct = ~head.c;
      4'b0100: ct = head.n;
      4'b0101: ct = ~head.n;
      4'b0110: ct = head.v;
      4'b0111: ct = ~head.v;
      4'b1000: ct = head.c & ~head.z;
      4'b1001: ct = ~head.c | head.z;
      4'b1010: ct = (head.n == head.v);
      4'b1011: ct = (head.n != head.v);
      4'b1100: ct = ~head.z & (head.n == head.v);
      4'b1101: ct = head.z | (head.n != head.v);
      4'b1110: ct = 1'b1;
      4'b1111: ct = 1'b0;
      default: ct = 1'b0;
    endcase
  end

  assign out_y         = head.y;
  assign out_n         = head.n;
  assign out_v         = head.v;
  assign out_c         = head.c;
  assign out_z         = head.z;
  assign out_cond_true = out_valid & ct;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed bench for alu_flag_stage: handshake, status register,
// flag snapshots and condition evaluation.
module tb_alu_flag_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_y;
  logic       in_n, in_v, in_c, in_z;
  logic       flag_we;
  logic [3:0] cond;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_n, out_v, out_c, out_z;
  logic       out_cond_true;
  logic       stat_n, stat_v, stat_c, stat_z;

  int total;
  int bad;

  logic [14:0] obs;
  logic [3:0]  st;

  assign obs = {out_valid, in_ready, out_y,
                out_n, out_v, out_c, out_z, out_cond_true};
  assign st  = {stat_n, stat_v, stat_c, stat_z};

  alu_flag_stage #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_y          (in_y),
    .in_n          (in_n),
    .in_v          (in_v),
    .in_c          (in_c),
    .in_z          (in_z),
    .flag_we       (flag_we),
    .cond          (cond),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_y         (out_y),
    .out_n         (out_n),
    .out_v         (out_v),
    .out_c         (out_c),
    .out_z         (out_z),
    .out_cond_true (out_cond_true),
    .stat_n        (stat_n),
    .stat_v        (stat_v),
    .stat_c        (stat_c),
    .stat_z        (stat_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] y, input logic [3:0] nvcz,
                       input logic we, input logic [3:0] cc);
    in_valid = 1'b1;
    in_y     = y;
    {in_n, in_v, in_c, in_z} = nvcz;
    flag_we  = we;
    cond     = cc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_y = '0;
    {in_n, in_v, in_c, in_z} = '0;
    flag_we = 1'b0; cond = '0; out_ready = 1'b0;
    #12;
    total++;
    if (obs !== 15'b01_00000000_0000_0) begin
      bad++;
      $display("FAIL reset_out got=%h exp=%h", obs, 15'h2000);
    end
    total++;
    if (st !== 4'b0000) begin
      bad++;
      $display("FAIL reset_stat got=%b exp=0000", st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass();
    logic [14:0] e;
    out_ready = 1'b1;
    drive(8'h80, 4'b1000, 1'b1, 4'b0100);
    step();
    in_valid = 1'b0;
    e = {1'b1, 1'b1, 8'h80, 4'b1000, 1'b1};
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL pass_out got=%h exp=%h", obs, e);
    end
    total++;
    if (st !== 4'b1000) begin
      bad++;
      $display("FAIL pass_stat got=%b exp=1000", st);
    end
    step();
    e = {1'b0, 1'b1, 8'h80, 4'b1000, 1'b0};
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL pass_drain got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_flag_hold();
    logic [14:0] e;
    out_ready = 1'b1;
    drive(8'h00, 4'b0001, 1'b1, 4'b0001);
    step();
    e = {1'b1, 1'b1, 8'h00, 4'b0001, 1'b0};
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL hold_first got=%h exp=%h", obs, e);
    end
    drive(8'h05, 4'b0000, 1'b0, 4'b0000);
    step();
    in_valid = 1'b0;
    e = {1'b1, 1'b1, 8'h05, 4'b0001, 1'b1};
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL hold_second got=%h exp=%h", obs, e);
    end
    total++;
    if (st !== 4'b0001) begin
      bad++;
      $display("FAIL hold_stat got=%b exp=0001", st);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] ey [5];
    logic       er [5];
    logic [14:0] e;
    ey = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22};
    er = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b0;
    drive(8'h11, 4'b0000, 1'b0, 4'b1110);
    step();
    drive(8'h22, 4'b0000, 1'b0, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive(8'h33, 4'b0000, 1'b0, 4'b1110);
      if (i == 3) out_ready = 1'b1;
      if (i > 0 || i == 0) begin
        e = {1'b1, er[i], ey[i], 4'b0001, 1'b1};
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL bp_%0d got=%h exp=%h", i, obs, e);
        end
      end
      step();
    end
    in_valid = 1'b0;
    e = {1'b1, 1'b1, 8'h33, 4'b0001, 1'b1};
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL bp_last got=%h exp=%h", obs, e);
    end
    step();
    e = {1'b0, 1'b1, 8'h33, 4'b0001, 1'b0};
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL bp_drain got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] e;
    out_ready = 1'b0;
    drive(8'hAA, 4'b0000, 1'b0, 4'b1110);
    step();
    e = {1'b1, 1'b1, 8'hAA, 4'b0001, 1'b1};
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL b2b_head got=%h exp=%h", obs, e);
    end
    drive(8'hBB, 4'b0000, 1'b0, 4'b1110);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    e = {1'b1, 1'b1, 8'hBB, 4'b0001, 1'b1};
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL b2b_swap got=%h exp=%h", obs, e);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_signed();
    logic [3:0] cc [4];
    logic       ex [4];
    logic [14:0] e;
    cc = '{4'b1010, 4'b1011, 4'b1100, 4'b1111};
    ex = '{1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'(i + 1), 4'b1100, 1'b1, cc[i]);
      step();
      e = {1'b1, 1'b1, 8'(i + 1), 4'b1100, ex[i]};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL signed_%0d got=%h exp=%h", i, obs, e);
      end
    end
    in_valid = 1'b0;
    {in_n, in_v, in_c, in_z} = 4'b0011;
    flag_we = 1'b1;
    step();
    total++;
    if (st !== 4'b1100) begin
      bad++;
      $display("FAIL idle_flags got=%b exp=1100", st);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(8'h5A, 4'b0010, 1'b1, 4'b1110);
    step();
    drive(8'hA5, 4'b0110, 1'b1, 4'b1110);
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL two_state got=%b exp=10", {out_valid, in_ready});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 15'b01_00000000_0000_0) begin
      bad++;
      $display("FAIL rst_mid_out got=%h exp=%h", obs, 15'h2000);
    end
    total++;
    if (st !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid_stat got=%b exp=0000", st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== 15'b01_00000000_0000_0) begin
      bad++;
      $display("FAIL rst_after got=%h exp=%h", obs, 15'h2000);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_pass();
    test_flag_hold();
    test_backpressure();
    test_back_to_back();
    test_signed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
